rmw_cmd_queue: RTL
==================

// Module: rmw_cmd_queue
// PURPOSE
//  Host-facing command front end for the read-modify-write (byteswap) engine.
//  The host programs 64-bit target addresses over the OCL AXI4-Lite slave. A doorbell
//  write queues each address in a FIFO. The FIFO head is issued to the engine over a
//  valid/ready command port. Engine completions are counted and readable by the host.
// PARAMETERS
//  DEPTH      8    FIFO entries; power of 2, >=2
//  CNT_W      32   width of DONE_COUNT
// PORTS
//  aclk        in   1   clock
//  aresetn     in   1   reset, synchronous, active-low
//  s_awvalid   in   1   AXI-Lite write address valid
//  s_awready   out  1   write address ready
//  s_awaddr    in   32  write address; bits [4:2] decoded
//  s_wvalid    in   1   write data valid
//  s_wready    out  1   write data ready
//  s_wdata     in   32  write data
//  s_wstrb     in   4   ignored; full-word writes only
//  s_bvalid    out  1   write response valid
//  s_bready    in   1   write response ready
//  s_bresp     out  2   00 OKAY, 10 SLVERR
//  s_arvalid   in   1   read address valid
//  s_arready   out  1   read address ready
//  s_araddr    in   32  read address; bits [4:2] decoded
//  s_rvalid    out  1   read data valid
//  s_rready    in   1   read data ready
//  s_rdata     out  32  read data
//  s_rresp     out  2   always 00
//  cmd_valid   out  1   FIFO not empty
//  cmd_ready   in   1   engine accepts head (engine idle)
//  cmd_addr    out  64  FIFO head address, first-word fall-through
//  done_pulse  in   1   one-cycle pulse per engine completion
// BEHAVIOUR
//  Reset: all ready/valid outputs 0 for the reset cycle; FIFO empty; regs, OVF, DONE_COUNT
//   zero; bresp/rdata zero. Reset mid-transaction drops queued commands and in-flight
//   AXI beats.
//  Register map (byte offset): 0x00 ADDR_LO RW; 0x04 ADDR_HI RW; 0x08 DOORBELL WO
//   (reads 0); 0x0C STATUS RO = {OVF[31], FULL[17], EMPTY[16], count[15:0]};
//   0x10 DONE_COUNT RO, any write clears. Other offsets: writes ignored (OKAY); reads
//   return 0.
//  Write channel:
//   - AW and W are accepted independently. awready = !aw_held & !bvalid;
//     wready = !w_held & !bvalid.
//   - Once both are held, the register update occurs in that cycle, bvalid rises next
//     cycle, and both holds clear.
//   - bvalid stays high until bready; no new AW/W is accepted meanwhile.
//  Read channel:
//   - arready = !rvalid. rdata is registered and presented with rvalid 1 cycle after the
//     AR handshake.
//   - rvalid holds until rready.
//  Doorbell: pushes {ADDR_HI,ADDR_LO} as captured at the write cycle.
//   - If FULL at that cycle: no push, OVF set sticky, bresp=SLVERR. The full check uses
//     pre-pop state, so a same-cycle pop does not admit the push.
//   - OVF clears only on reset.
//  Command port: cmd_valid = !EMPTY. A pop occurs on cmd_valid & cmd_ready.
//   - cmd_addr is stable while cmd_valid & !cmd_ready.
//   - Push and pop in the same cycle on a non-full, non-empty FIFO keeps count unchanged.
//   - A push to an empty FIFO shows cmd_valid the next cycle.
//  Pointers: log2(DEPTH)+1 bits with wrap bit. FULL when MSBs differ and the rest are
//   equal; EMPTY when the pointers are equal.
//  DONE_COUNT: +1 per done_pulse, wraps at 2^CNT_W to 0. Write-clear and pulse in the
//   same cycle gives 1.
// TESTING
//  1. Reset, read 0x0C -> 0x0001_0000 (EMPTY); cmd_valid=0; all AXI valids 0.
//  2. Write LO=0x1000, HI=0x1, DOORBELL; cmd_ready=0 -> cmd_valid=1,
//     cmd_addr=0x1_0000_1000, STATUS count=1, stable until cmd_ready=1, then EMPTY.
//  3. Nine doorbells with cmd_ready=0 (DEPTH=8) -> 9th bresp=10, STATUS=0x8002_0008;
//     drain gives 8 addresses in order.
//  4. AW presented 3 cycles before W, with bready held 0 for 2 cycles -> a single write,
//     bvalid held, awready/wready low until B handshake.
//  5. Preload DONE_COUNT=0xFFFF_FFFF via pulses (force), pulse -> reads 0; write 0x10
//     alongside pulse -> reads 1.
//  6. Assert aresetn=0 with 3 entries queued and rvalid pending -> EMPTY, rvalid=0,
//     DONE_COUNT=0 next cycle.

Source files
------------

// File: rtl/rmw_cmd_queue_if.sv
// Host AXI4-Lite register port plus engine command/completion signals for rmw_cmd_queue.
// slave is the queue's view; master is the host/engine side.
interface rmw_cmd_queue_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_araddr;
  logic        s_rvalid;
  logic        s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_addr;
  logic        done_pulse;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready, cmd_ready, done_pulse,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp, cmd_valid, cmd_addr
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready, cmd_ready, done_pulse,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp, cmd_valid, cmd_addr
  );
endinterface

// File: rtl/rmw_cmd_queue.sv
// Host command front end for the byteswap RMW engine: AXI-Lite registers, a doorbell-fed
// address FIFO issued over a valid/ready command port, and a completion counter.
module rmw_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic             aclk,
  input logic             aresetn,
  rmw_cmd_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    REG_ADDR_LO  = 3'd0,
    REG_ADDR_HI  = 3'd1,
    REG_DOORBELL = 3'd2,
    REG_STATUS   = 3'd3,
    REG_DONE     = 3'd4
  } reg_sel_e;

  logic             aw_held, w_held;
  logic [2:0]       aw_sel;
  logic [31:0]      w_data;
  logic             bvalid, rvalid;
  logic [1:0]       bresp;
  logic [31:0]      rdata;
  logic [31:0]      addr_lo, addr_hi;
  logic             ovf;
  logic [CNT_W-1:0] done_cnt;
  logic [63:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  logic             awready, wready, arready, cmd_valid;
  logic             full, empty, wr_fire, push, pop, db_ovf, done_clr;
  logic [AW:0]      fifo_cnt;
  logic [31:0]      status, rd_val;
  reg_sel_e         wr_sel, rd_sel;
  logic             unused_bits;

  // Handshake outputs are forced low while reset is asserted so nothing is accepted then.
  always_comb begin
    awready   = aresetn & ~aw_held & ~bvalid;
    wready    = aresetn & ~w_held & ~bvalid;
    arready   = aresetn & ~rvalid;
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    cmd_valid = aresetn & ~empty;
    fifo_cnt  = wr_ptr - rd_ptr;
    wr_fire   = aresetn & aw_held & w_held;
    wr_sel    = reg_sel_e'(aw_sel);
    rd_sel    = reg_sel_e'(bus.s_araddr[4:2]);
    push      = wr_fire & (wr_sel == REG_DOORBELL) & ~full;
    db_ovf    = wr_fire & (wr_sel == REG_DOORBELL) & full;
    pop       = cmd_valid & bus.cmd_ready;
    done_clr  = wr_fire & (wr_sel == REG_DONE);
    status    = {ovf, 13'd0, full, empty, 16'(fifo_cnt)};
  end

  always_comb begin
    rd_val = '0;
    case (rd_sel)
      REG_ADDR_LO: rd_val = addr_lo;
      REG_ADDR_HI: rd_val = addr_hi;
      REG_STATUS:  rd_val = status;
      REG_DONE:    rd_val = 32'(done_cnt);
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_sel   <= '0;
      w_data   <= '0;
      bvalid   <= 1'b0;
      bresp    <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      addr_lo  <= '0;
      addr_hi  <= '0;
      ovf      <= 1'b0;
      done_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (bus.s_awvalid && awready) begin
        aw_held <= 1'b1;
        aw_sel  <= bus.s_awaddr[4:2];
      end
      if (bus.s_wvalid && wready) begin
        w_held <= 1'b1;
        w_data <= bus.s_wdata;
      end

      if (wr_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= db_ovf ? 2'b10 : 2'b00;
        case (wr_sel)
          REG_ADDR_LO: addr_lo <= w_data;
          REG_ADDR_HI: addr_hi <= w_data;
          default:     ;
        endcase
      end else if (bvalid && bus.s_bready) begin
        bvalid <= 1'b0;
      end

      if (db_ovf) ovf <= 1'b1;

      if (bus.s_arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end else if (rvalid && bus.s_rready) begin
        rvalid <= 1'b0;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // A clear coinciding with a completion keeps that completion.
      if (done_clr)            done_cnt <= CNT_W'(bus.done_pulse);
      else if (bus.done_pulse) done_cnt <= done_cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {addr_hi, addr_lo};
  end

  assign bus.s_awready = awready;
  assign bus.s_wready  = wready;
  assign bus.s_bvalid  = bvalid;
  assign bus.s_bresp   = bresp;
  assign bus.s_arready = arready;
  assign bus.s_rvalid  = rvalid;
  assign bus.s_rdata   = rdata;
  assign bus.s_rresp   = 2'b00;
  assign bus.cmd_valid = cmd_valid;
  assign bus.cmd_addr  = mem[rd_ptr[AW-1:0]];

  assign unused_bits = ^{bus.s_wstrb, bus.s_awaddr[31:5], bus.s_awaddr[1:0],
                         bus.s_araddr[31:5], bus.s_araddr[1:0]};

endmodule
